// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU widths, drain FSM states and clog2 helper
package tpu_pkg;

    localparam int BF16_W        = 16;
    localparam int FP8_W         = 8;
    localparam int BF16_SIGN_BIT = BF16_W - 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    // Ceiling log2; returns 0 for values <= 1 so callers clamp to a 1-bit minimum.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/drain_fmt.sv
// rtl/drain_fmt.sv - per-word output formatting; ReLU when DRAIN_RELU_EN is defined
module drain_fmt
    import tpu_pkg::*;
(
    input  logic [BF16_W-1:0] word_i,
    output logic [BF16_W-1:0] word_o
);

`ifdef DRAIN_RELU_EN
    // Any negative word, including -0, is clamped to +0.
    always_comb begin
        word_o = word_i;
        if (word_i[BF16_SIGN_BIT]) begin
            word_o = '0;
        end
    end
`else
    // Raw passthrough, bit-exact.
    always_comb begin
        word_o = word_i;
    end
`endif

endmodule

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - snapshots the PE accumulators and streams them row-major (option: DRAIN_RELU_EN)
module systolic_drain
    import tpu_pkg::*;
#(
    parameter  int N      = 2,
    parameter  int DATA_W = 16,
    localparam int RW     = (clog2(N) < 1) ? 1 : clog2(N)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N*N*DATA_W-1:0] c_flat,
    input  logic                  capture,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [RW-1:0]         out_row,
    output logic [RW-1:0]         out_col,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overrun
);

    localparam int            IW       = (clog2(N * N) < 1) ? 1 : clog2(N * N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

    drain_state_e            state_q, state_d;
    logic [N*N*DATA_W-1:0]   snap_q, snap_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    overrun_q, overrun_d;

    logic                    streaming;
    logic                    is_last;
    logic                    fire;
    logic [DATA_W-1:0]       word_raw;
    logic [DATA_W-1:0]       word_fmt;

    assign streaming = (state_q == STREAM);
    assign is_last   = (idx_q == LAST_IDX);
    assign fire      = streaming && out_ready;
    assign word_raw  = snap_q[int'(idx_q) * DATA_W +: DATA_W];

    drain_fmt u_fmt (
        .word_i (word_raw),
        .word_o (word_fmt)
    );

    // State, snapshot, index and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: capture from IDLE or on the final handshake; otherwise advance on handshakes.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    snap_d  = c_flat;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fire && is_last) begin
                    if (capture) begin
                        snap_d = c_flat;
                        idx_d  = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    if (fire) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come only from registered state; word fields are zero while idle.
    always_comb begin
        out_valid = streaming;
        busy      = streaming;
        overrun   = overrun_q;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (streaming) begin
            out_data = word_fmt;
            out_row  = RW'(int'(idx_q) / N);
            out_col  = RW'(int'(idx_q) % N);
            out_last = is_last;
        end
    end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output stage downstream of the N x N PE systolic array; consumes the BF16 accumulators (one per PE) once a matmul tile completes.
- Snapshots all N*N results in one cycle, so the array is free to start the next tile (clear) immediately.
- Streams the results row-major over a valid/ready interface toward the host/writeback path.

Parameters:
- N, 2, array dimension; N*N results per tile (N >= 1).
- DATA_W, 16, result width (BF16); fixed at 16 in this design.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- c_flat  input  N*N*DATA_W  PE accumulators; cell (r,c) at bits [(r*N+c)*16 +: 16].
- capture  input  1  single-cycle pulse from controller: results in c_flat are final this cycle.
- out_ready  input  1  downstream can accept a word.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_data  output  16  BF16 result word.
- out_row  output  clog2(N) (min 1)  row index of out_data.
- out_col  output  clog2(N) (min 1)  column index of out_data.
- out_last  output  1  high with the final word (index N*N-1) of a tile.
- busy  output  1  snapshot held and not fully drained.
- overrun  output  1  sticky: capture arrived while a tile was still streaming.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, snapshot cleared to 0, index=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, overrun=0. Reset mid-stream discards the tile without completing it.
- FSM states: IDLE, STREAM.
- IDLE + capture=1: at the edge, snapshot <= c_flat, index <= 0, go to STREAM. out_valid=1 from the next cycle (1-cycle latency capture->first word).
- STREAM: out_data = snapshot[index]; out_row = index / N; out_col = index % N; out_last = (index == N*N-1).
- Handshake fires on out_valid & out_ready.
  - Not last: index increments.
  - Last, with capture=1 in the same cycle: new snapshot is taken, index <= 0, stay in STREAM (back-to-back tiles, no bubble).
  - Last, capture=0: go to IDLE; out_valid=0 next cycle.
- Stall: while out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable. The snapshot never changes mid-tile.
- capture in STREAM, other than on the last handshake: ignored (snapshot untouched) and overrun <= 1. overrun clears only on reset.
- busy = (state == STREAM).
- out_valid is registered; outputs derive from registered state only (no comb path from out_ready to out_valid).
- N=1: a single word with out_last=1.
- Index counter width is clog2(N*N) (min 1) and never wraps past N*N-1.

Optional Feature:
- DRAIN_RELU_EN defined: any word with sign bit set (including -0, 0x8000) is emitted as 0x0000; non-negative words pass unchanged. Applied on the output mux; the snapshot keeps raw values.
- Undefined: out_data is the raw snapshot word, bit-exact.

Decomposition:
- Shared package tpu_pkg:
  - BF16_W=16, FP8_W=8.
  - BF16 sign-bit position constant.
  - Drain FSM state enum {IDLE, STREAM}.
  - clog2 helper function.
- One natural sub-module: drain_fmt (combinational per-word formatting: ReLU under DRAIN_RELU_EN, else passthrough).
- FSM, counter and snapshot stay in systolic_drain.

Test Plan:
- Basic drain, N=2, out_ready=1: c_flat={16'h4040,16'hC000,16'h3F80,16'h0000}, capture pulse. Next 4 cycles out_data = 0000, 3F80, C000, 4040; row/col = (0,0), (0,1), (1,0), (1,1); out_last only on 4040; out_valid=0 and busy=0 after.
- Backpressure: out_ready toggling 1,0,0,1,... -> each word held stable during stalls; same sequence and no drops or duplicates.
- Snapshot isolation: change c_flat every cycle after capture -> streamed words equal the capture-cycle values.
- Back-to-back: capture asserted on the cycle of the last handshake with new c_flat={16'h3F80 x4} -> next cycle out_valid=1 with 3F80, index 0, no idle bubble.
- Overrun and reset: capture at index 1 -> overrun=1 and the stream continues unchanged. Then rst_n=0 mid-stream -> all outputs 0 next cycle, IDLE, overrun=0.
- DRAIN_RELU_EN build: the basic-drain vector yields 0000, 3F80, 0000, 4040; a 16'h8000 input yields 0000.
